// File: rtl/fp_addsub_ctrl.sv
// Sequencing FSM for the 8-bit float add/sub datapath (1/4/3 format, hidden 1).
// Drives one-hot datapath enables from datapath status and flags normalize overruns.
module fp_addsub_ctrl #(
  parameter int NORM_MAX = 6
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic greater,
  input  logic sign_gt,
  input  logic sign_lt,
  input  logic mant4,
  input  logic mant5,
  output logic en_gt,
  output logic en_ld,
  output logic en_addsub,
  output logic en_norm,
  output logic en_out,
  output logic ld_AB,
  output logic add_sub,
  output logic norm_lr,
  output logic busy,
  output logic done,
  output logic norm_err
);

  // state    | meaning
  // IDLE     | waiting for start
  // CMP      | datapath compares |A| and |B|
  // LOAD     | load larger/smaller operand, align smaller
  // ADDSUB   | add or subtract aligned mantissas
  // NORM     | one normalize step per cycle until hidden bit set or limit hit
  // OUT      | write result register s
  // DONE     | s valid, one-cycle done pulse
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMP    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ADDSUB = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [2:0] NORM_LIMIT = 3'(NORM_MAX);

  logic [2:0] state_q, state_d;
  logic [2:0] norm_cnt_q, norm_cnt_d;
  logic       norm_err_q, norm_err_d;
  logic       normalized;

  assign normalized = mant4 & ~mant5;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      norm_cnt_q <= 3'd0;
      norm_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      norm_cnt_q <= norm_cnt_d;
      norm_err_q <= norm_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    norm_cnt_d = norm_cnt_q;
    norm_err_d = norm_err_q;
    en_gt      = 1'b0;
    en_ld      = 1'b0;
    en_addsub  = 1'b0;
    en_norm    = 1'b0;
    en_out     = 1'b0;
    ld_AB      = 1'b0;
    add_sub    = 1'b0;
    norm_lr    = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CMP;
          norm_cnt_d = 3'd0;
          norm_err_d = 1'b0;
        end
      end
      S_CMP: begin
        en_gt   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        en_ld   = 1'b1;
        ld_AB   = greater;
        state_d = S_ADDSUB;
      end
      S_ADDSUB: begin
        en_addsub = 1'b1;
        add_sub   = ~(sign_gt ^ sign_lt);
        state_d   = S_NORM;
      end
      S_NORM: begin
        if (normalized) begin
          state_d = S_OUT;
        end else if (norm_cnt_q == NORM_LIMIT) begin
          // Step budget exhausted: give up and publish whatever is in s.
          norm_err_d = 1'b1;
          state_d    = S_OUT;
        end else begin
          en_norm    = 1'b1;
          norm_lr    = ~mant5;
          norm_cnt_d = norm_cnt_q + 3'd1;
        end
      end
      S_OUT: begin
        en_out  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign norm_err = norm_err_q;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Self-checking bench for fp_addsub_ctrl with a behavioural 8-bit float datapath
// and an arithmetic reference model for result, step count and latency.
module tb_fp_addsub_ctrl;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic start = 1'b0;
  logic greater, sign_gt, sign_lt, mant4, mant5;
  logic en_gt, en_ld, en_addsub, en_norm, en_out;
  logic ld_AB, add_sub, norm_lr, busy, done, norm_err;

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic       stub0 = 1'b0;

  logic       dp_gt, dp_sg, dp_sl;
  logic [3:0] dp_e;
  logic [4:0] dp_ml, dp_ms, dp_m;
  logic [7:0] dp_s;
  logic       force_n;
  logic [10:0] outs;

  always #5 clk = ~clk;

  fp_addsub_ctrl #(.NORM_MAX(6)) dut (
    .clk(clk), .clr_n(clr_n), .start(start),
    .greater(greater), .sign_gt(sign_gt), .sign_lt(sign_lt),
    .mant4(mant4), .mant5(mant5),
    .en_gt(en_gt), .en_ld(en_ld), .en_addsub(en_addsub), .en_norm(en_norm),
    .en_out(en_out), .ld_AB(ld_AB), .add_sub(add_sub), .norm_lr(norm_lr),
    .busy(busy), .done(done), .norm_err(norm_err)
  );

  assign outs = {en_gt, en_ld, en_addsub, en_norm, en_out, ld_AB, add_sub,
                 norm_lr, busy, done, norm_err};

  // Datapath stand-in: acts on the enables at the edge the FSM leaves each state.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dp_gt <= 1'b0; dp_sg <= 1'b0; dp_sl <= 1'b0; dp_e <= 4'd0;
      dp_ml <= 5'd0; dp_ms <= 5'd0; dp_m <= 5'd8; dp_s <= 8'd0;
    end else begin
      if (en_gt) dp_gt <= (A[6:0] >= B[6:0]);
      if (en_ld) begin
        if (ld_AB) begin
          dp_sg <= A[7]; dp_sl <= B[7]; dp_e <= A[6:3];
          dp_ml <= {2'b01, A[2:0]};
          dp_ms <= {2'b01, B[2:0]} >> (A[6:3] - B[6:3]);
        end else begin
          dp_sg <= B[7]; dp_sl <= A[7]; dp_e <= B[6:3];
          dp_ml <= {2'b01, B[2:0]};
          dp_ms <= {2'b01, A[2:0]} >> (B[6:3] - A[6:3]);
        end
      end
      if (en_addsub) dp_m <= add_sub ? dp_ml + dp_ms : dp_ml - dp_ms;
      if (en_norm) begin
        if (norm_lr) begin dp_m <= dp_m << 1; dp_e <= dp_e - 4'd1; end
        else begin dp_m <= dp_m >> 1; dp_e <= dp_e + 4'd1; end
      end
      if (en_out) dp_s <= (dp_m == 5'd0) ? 8'h00 : {dp_sg, dp_e, dp_m[2:0]};
    end
  end

  assign force_n = (dp_m == 5'd0) || (dp_e == 4'hF);
  assign greater = dp_gt;
  assign sign_gt = dp_sg;
  assign sign_lt = dp_sl;
  assign mant4   = stub0 ? 1'b0 : (force_n ? 1'b1 : dp_m[3]);
  assign mant5   = stub0 ? 1'b0 : (force_n ? 1'b0 : dp_m[4]);

  // Reference: real-valued add of 1.mmm * 2^e operands with integer mantissas.
  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] s, output int k,
                                 output logic lab, output logic asub, output logic lr);
    int el, es, ml, ms, r, e;
    logic sg, sl;
    lab = (a[6:0] >= b[6:0]);
    if (lab) begin
      el = int'(a[6:3]); ml = 8 + int'(a[2:0]); sg = a[7];
      es = int'(b[6:3]); ms = 8 + int'(b[2:0]); sl = b[7];
    end else begin
      el = int'(b[6:3]); ml = 8 + int'(b[2:0]); sg = b[7];
      es = int'(a[6:3]); ms = 8 + int'(a[2:0]); sl = a[7];
    end
    ms   = ms >> (el - es);
    asub = (sg == sl);
    r    = asub ? ml + ms : ml - ms;
    k = 0; e = el; lr = 1'b0;
    if (r == 0) begin
      s = 8'h00;
    end else begin
      while (r > 15) begin r = r / 2; e++; k++; end
      while (r < 8) begin r = r * 2; e--; k++; lr = 1'b1; end
      s = {sg, e[3:0], r[2:0]};
    end
  endfunction

  // Drives one operation and records what the controller did, cycle by cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic stub,
                        input int extra_start,
                        output int done_cyc, output int out_cyc, output int n_norm,
                        output int n_lr1, output logic ld_v, output logic as_v,
                        output int bad);
    done_cyc = -1; out_cyc = -1; n_norm = 0; n_lr1 = 0;
    ld_v = 1'bx; as_v = 1'bx; bad = 0;
    @(negedge clk);
    A = a; B = b; stub0 = stub; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = (cyc == extra_start);
      if ($countones({en_gt, en_ld, en_addsub, en_norm, en_out}) > 1) bad++;
      if ((ld_AB && !en_ld) || (add_sub && !en_addsub) || (norm_lr && !en_norm)) bad++;
      if (en_ld) ld_v = ld_AB;
      if (en_addsub) as_v = add_sub;
      if (en_norm) begin n_norm++; if (norm_lr) n_lr1++; end
      if (en_out && out_cyc < 0) out_cyc = cyc;
      if (done_cyc >= 0) begin
        if (busy !== 1'b0 || done !== 1'b0) bad++;
        break;
      end
      if (busy !== 1'b1) bad++;
      if (done === 1'b1) done_cyc = cyc;
    end
    start = 1'b0;
    stub0 = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_asrt++;
    if (outs !== 11'd0) begin n_fail++; $display("FAIL reset_outputs: got %b required 0", outs); end
    clr_n = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    n_asrt++;
    if (outs !== 11'd0) begin n_fail++; $display("FAIL idle_outputs: got %b required 0", outs); end
  endtask

  task automatic test_directed();
    int dc, oc, nn, nl, bad;
    logic lv, av;
    run_op(8'h18, 8'h18, 1'b0, -1, dc, oc, nn, nl, lv, av, bad);
    n_asrt++; if (dc !== 7) begin n_fail++; $display("FAIL t1_done_cycle: got %0d required 7", dc); end
    n_asrt++; if (nn !== 1 || nl !== 0) begin n_fail++; $display("FAIL t1_norm: pulses %0d left %0d required 1/0", nn, nl); end
    n_asrt++; if (dp_s !== 8'h20) begin n_fail++; $display("FAIL t1_s: got %h required 20", dp_s); end
    n_asrt++; if (norm_err !== 1'b0 || bad !== 0) begin n_fail++; $display("FAIL t1_err_proto: err %b bad %0d required 0/0", norm_err, bad); end

    run_op(8'h1C, 8'h98, 1'b0, -1, dc, oc, nn, nl, lv, av, bad);
    n_asrt++; if (av !== 1'b0) begin n_fail++; $display("FAIL t2_add_sub: got %b required 0", av); end
    n_asrt++; if (nn !== 1 || nl !== 1) begin n_fail++; $display("FAIL t2_norm: pulses %0d left %0d required 1/1", nn, nl); end
    n_asrt++; if (dp_s !== 8'h10 || dc !== 7) begin n_fail++; $display("FAIL t2_s_done: s %h done %0d required 10/7", dp_s, dc); end

    run_op(8'h10, 8'h18, 1'b0, -1, dc, oc, nn, nl, lv, av, bad);
    n_asrt++; if (lv !== 1'b0 || av !== 1'b1) begin n_fail++; $display("FAIL t3_ld_add: ld_AB %b add_sub %b required 0/1", lv, av); end
    n_asrt++; if (dp_s !== 8'h1C || dc !== 6 || nn !== 0) begin n_fail++; $display("FAIL t3_s_done: s %h done %0d norm %0d required 1C/6/0", dp_s, dc, nn); end
  endtask

  task automatic test_norm_limit();
    int dc, oc, nn, nl, bad;
    logic lv, av;
    run_op(8'h18, 8'h18, 1'b1, -1, dc, oc, nn, nl, lv, av, bad);
    n_asrt++; if (nn !== 6) begin n_fail++; $display("FAIL lim_pulses: got %0d required 6", nn); end
    n_asrt++; if (dc !== 12 || oc !== 11) begin n_fail++; $display("FAIL lim_timing: done %0d out %0d required 12/11", dc, oc); end
    repeat (3) @(negedge clk);
    n_asrt++; if (norm_err !== 1'b1) begin n_fail++; $display("FAIL lim_err_held: got %b required 1", norm_err); end
    n_asrt++; if (bad !== 0) begin n_fail++; $display("FAIL lim_proto: got %0d violations required 0", bad); end
    run_op(8'h18, 8'h18, 1'b0, -1, dc, oc, nn, nl, lv, av, bad);
    n_asrt++; if (norm_err !== 1'b0 || dc !== 7) begin n_fail++; $display("FAIL lim_clear: err %b done %0d required 0/7", norm_err, dc); end
  endtask

  task automatic test_start_ignored();
    int dc, oc, nn, nl, bad, extra;
    logic lv, av;
    run_op(8'h18, 8'h18, 1'b0, 3, dc, oc, nn, nl, lv, av, bad);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_asrt++; if (dc !== 7 || extra !== 0) begin n_fail++; $display("FAIL ign_start: done %0d later activity %0d required 7/0", dc, extra); end
    run_op(8'h1C, 8'h98, 1'b0, -1, dc, oc, nn, nl, lv, av, bad);
    n_asrt++; if (dc !== 7 || dp_s !== 8'h10) begin n_fail++; $display("FAIL ign_next: done %0d s %h required 7/10", dc, dp_s); end
  endtask

  task automatic test_abort();
    int dc, oc, nn, nl, bad, seen;
    logic lv, av;
    @(negedge clk);
    A = 8'h18; B = 8'h18; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_asrt++; if (en_norm !== 1'b1) begin n_fail++; $display("FAIL abort_in_norm: en_norm %b required 1", en_norm); end
    #1 clr_n = 1'b0;
    #1;
    n_asrt++; if (outs !== 11'd0) begin n_fail++; $display("FAIL abort_outputs: got %b required 0", outs); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (outs !== 11'd0) seen++; end
    clr_n = 1'b1;
    n_asrt++; if (seen !== 0) begin n_fail++; $display("FAIL abort_quiet: %0d active cycles required 0", seen); end
    run_op(8'h10, 8'h18, 1'b0, -1, dc, oc, nn, nl, lv, av, bad);
    n_asrt++; if (dc !== 6 || dp_s !== 8'h1C || bad !== 0) begin n_fail++; $display("FAIL abort_fresh: done %0d s %h bad %0d required 6/1C/0", dc, dp_s, bad); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1; d2 = -1;
    @(negedge clk);
    A = 8'h18; B = 8'h18; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) d1 = cyc;
        else begin d2 = cyc; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_asrt++; if (d1 !== 7 || d2 !== 15) begin n_fail++; $display("FAIL b2b_done: first %0d second %0d required 7/15", d1, d2); end
    n_asrt++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b required 0", busy); end
  endtask

  task automatic test_random();
    int dc, oc, nn, nl, bad, k;
    logic lv, av, lab, asub, lr;
    logic [7:0] a, b, s;
    for (int i = 0; i < 24; i++) begin
      a[7] = 1'($urandom_range(0, 1));
      a[6:3] = 4'($urandom_range(4, 12));
      a[2:0] = 3'($urandom());
      b[7] = 1'($urandom_range(0, 1));
      b[6:3] = 4'($urandom_range(4, 12));
      b[2:0] = 3'($urandom());
      if (i == 0) b = a ^ 8'h80;
      if (i == 1) b = a;
      if (i == 2) begin b[7] = ~a[7]; b[6:3] = a[6:3]; end
      ref_op(a, b, s, k, lab, asub, lr);
      run_op(a, b, 1'b0, -1, dc, oc, nn, nl, lv, av, bad);
      n_asrt++; if (dc !== 6 + k) begin n_fail++; $display("FAIL rnd_done %h+%h: got %0d required %0d", a, b, dc, 6 + k); end
      n_asrt++; if (nn !== k || nl !== (lr ? k : 0)) begin n_fail++; $display("FAIL rnd_norm %h+%h: pulses %0d left %0d required %0d/%0d", a, b, nn, nl, k, lr ? k : 0); end
      n_asrt++; if (lv !== lab || av !== asub) begin n_fail++; $display("FAIL rnd_ctl %h+%h: ld_AB %b add_sub %b required %b/%b", a, b, lv, av, lab, asub); end
      n_asrt++; if (dp_s !== s) begin n_fail++; $display("FAIL rnd_s %h+%h: got %h required %h", a, b, dp_s, s); end
      n_asrt++; if (bad !== 0 || norm_err !== 1'b0 || oc !== dc - 1) begin n_fail++; $display("FAIL rnd_proto %h+%h: bad %0d err %b out %0d", a, b, bad, norm_err, oc); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_norm_limit();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
